serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder/subtractor controller that sequences the single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake and shifts them through the cell, holding the carry in a flop between bits. It then presents the assembled result with a one-cycle done pulse. It sits between a requesting control unit and the shared one-bit full-adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- sub  in  1  0 = A+B+cin, 1 = A−B (cin ignored); latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- cin  in  1  carry-in for add mode; latched with start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when result is valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- cout  out  1  final carry-out (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow of the operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch a into shift reg SA and b into SB, where SB is b for add and ~b for sub. Load carry flop with cin for add and 1 for sub. Clear the bit counter, clear the result shift reg, and go to RUN.
- RUN: the full-adder cell sees A=SA[0], B=SB[0], Cin=carry. Each cycle:
  - the cell's S shifts into the result reg MSB, with the result shifting right;
  - carry <= cell C;
  - SA and SB shift right;
  - the counter increments.
  - After the cycle processing bit WIDTH−1, go to DONE.
- On the final bit, also capture ovf = carry-into-MSB XOR carry-out-of-MSB.
- DONE: done=1 for exactly one cycle. Drive sum from the result reg, cout from the carry flop, and ovf from its flop. Return to IDLE.
- start while not ready is ignored; no queuing.
- sub and operands are latched at acceptance only. Input changes during RUN have no effect.
- Reset at any time, including mid-RUN: go to IDLE and clear all outputs immediately. The in-flight operation is discarded with no done pulse.
- Width rules: the counter is $clog2(WIDTH) bits. All arithmetic is modulo 2^WIDTH; carry beyond the MSB appears only on cout.

## Timing
- Reset values: ready=1, done=0, sum=0, cout=0, ovf=0, state=IDLE.
- start is accepted on edge E0 (ready=1, start=1). RUN occupies the WIDTH cycles after E0.
- done is high in the cycle after the last RUN edge, i.e. start-to-done latency is WIDTH+1 cycles.
- sum, cout and ovf are valid no later than the cycle done is high. They hold until the edge accepting the next start.
- ready returns high the cycle after done. Throughput is one operation per WIDTH+2 cycles.
- start asserted in the done cycle is ignored, because ready=0 then.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package serial_add_pkg holds the state typedef (IDLE/RUN/DONE) and the mode constants ADD=0 and SUB=1.
- One sub-module: the existing one-bit full-adder cell `full` (S, C, A, B, Cin), instantiated once.
- The controller contains the FSM, counter, three shift regs, and the carry and ovf flops.

## Test plan
- Add, WIDTH=8: a=8'h0F, b=8'h01, cin=0, sub=0 → done at start+9 cycles; sum=8'h10, cout=0, ovf=0.
- Carry/overflow, add: a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 → sum=8'h80, ovf=1.
- Subtract: a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0 (borrow), ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, ovf=1.
- Handshake: pulse start again in every cycle of RUN with different operands → ignored; the first result is unchanged, done fires exactly once, and ready is low through RUN and DONE.
- Reset mid-operation: assert rst at RUN bit 3 → immediately ready=1, sum=0, no done pulse. A new start after release produces a correct, unpolluted result.
- Back-to-back: start held high continuously with random operands over 1000 operations → each result matches a+b+cin / a−b mod 256, and done pulses are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder/subtractor controller.
// The FSM state encoding and the add/subtract mode constants live here.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a control unit (master) and the serial adder (slave).
// Operands and mode travel with start; the result comes back with a done pulse.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  ready, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_full.sv
// One-bit full-adder cell shared by the serial datapath.
module full (
    output logic S,
    output logic C,
    input  logic A,
    input  logic B,
    input  logic Cin
);
    assign S = A ^ B ^ Cin;
    assign C = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one operand bit per clock, LSB first,
// through a single full-adder cell, with the carry held in a flop between bits.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             ready_reg;
    logic             done_reg;

    logic             cell_s;
    logic             cell_c;
    logic             last_bit;
    logic             accept;

    full u_full (
        .S   (cell_s),
        .C   (cell_c),
        .A   (sa_reg[0]),
        .B   (sb_reg[0]),
        .Cin (carry_reg)
    );

    assign last_bit = (count_reg == CW'(WIDTH - 1));
    assign accept   = (state_reg == IDLE) && bus.start;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            done_reg  <= (state_next == DONE);
        end
    end

    // Subtraction is A + ~B + 1, so the inversion and the forced carry happen at load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_reg    <= '0;
            sb_reg    <= '0;
            res_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            sa_reg    <= bus.a;
            sb_reg    <= (bus.sub == SUB) ? ~bus.b : bus.b;
            carry_reg <= (bus.sub == SUB) ? 1'b1 : bus.cin;
            res_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (state_reg == RUN) begin
            res_reg   <= {cell_s, res_reg[WIDTH-1:1]};
            sa_reg    <= sa_reg >> 1;
            sb_reg    <= sb_reg >> 1;
            carry_reg <= cell_c;
            count_reg <= count_reg + CW'(1);
            // On the MSB, carry_reg is the carry into it and cell_c the carry out.
            if (last_bit) begin
                ovf_reg <= carry_reg ^ cell_c;
            end
        end
    end

    assign bus.ready = ready_reg;
    assign bus.done  = done_reg;
    assign bus.sum   = res_reg;
    assign bus.cout  = carry_reg;
    assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: accepted requests push an arithmetic
// model result, a negedge monitor pops and compares on each done pulse.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_count = 0;
    int b2b_done = 0;
    int last_done_cyc = 0;
    bit b2b_mode = 1'b0;
    logic [WIDTH-1:0] hold_sum = '0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t e;
        int ua, ub, sa, sb, r, exact;
        ua = int'(a);
        ub = int'(b);
        sa = a[WIDTH-1] ? ua - (1 << WIDTH) : ua;
        sb = b[WIDTH-1] ? ub - (1 << WIDTH) : ub;
        if (sub == SUB) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
            exact  = sa - sb;
        end else begin
            r      = ua + ub + int'(cin);
            e.cout = (r >= (1 << WIDTH));
            exact  = sa + sb + int'(cin);
        end
        e.sum     = WIDTH'(r);
        e.ovf     = (exact > (1 << (WIDTH - 1)) - 1) || (exact < -(1 << (WIDTH - 1)));
        e.acc_cyc = acc;
        return e;
    endfunction

    // Acceptance observer: records the request the DUT takes on this edge.
    always @(posedge clk) begin
        if (!rst && bus.ready && bus.start)
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, cyc));
        cyc++;
    end

    // Monitor: reset values, ready tracking, hold of sum, and result checks on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_ready", bus.ready, 1);
            check("rst_done", bus.done, 0);
            check("rst_sum", bus.sum, 0);
            check("rst_cout", bus.cout, 0);
            check("rst_ovf", bus.ovf, 0);
            exp_q.delete();
            hold_sum = '0;
        end else begin
            check("ready", bus.ready, (exp_q.size() == 0));
            if (exp_q.size() == 0)
                check("sum_hold", bus.sum, hold_sum);
            if (bus.done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 with no request outstanding (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", bus.sum, e.sum);
                    check("cout", bus.cout, e.cout);
                    check("ovf", bus.ovf, e.ovf);
                    check("latency", cyc - e.acc_cyc, WIDTH + 1);
                    hold_sum = e.sum;
                end
                if (b2b_mode) begin
                    if (b2b_done > 0)
                        check("done_spacing", cyc - last_done_cyc, WIDTH + 2);
                    b2b_done++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: not idle after %0d cycles", budget);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        wait_idle(4 * WIDTH);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic randomize_inputs();
        bus.a   = WIDTH'($urandom);
        bus.b   = WIDTH'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    initial begin
        int dc0;
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = ADD;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(8'h0F, 8'h01, 1'b0, ADD);
        issue(8'hFF, 8'h01, 1'b1, ADD);
        issue(8'h7F, 8'h01, 1'b0, ADD);
        issue(8'h05, 8'h07, 1'b0, SUB);
        issue(8'h80, 8'h01, 1'b0, SUB);
        issue(8'h00, 8'h00, 1'b1, SUB);
        issue(8'h80, 8'h80, 1'b0, ADD);

        for (int i = 0; i < 200; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));

        // Start kept high with fresh operands through RUN and DONE: only one result.
        wait_idle(4 * WIDTH);
        dc0 = done_count;
        bus.a = 8'h3C; bus.b = 8'h5A; bus.cin = 1'b1; bus.sub = ADD;
        bus.start = 1'b1;
        repeat (WIDTH + 1) begin
            @(negedge clk);
            randomize_inputs();
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(4 * WIDTH);
        check("handshake_done_count", done_count - dc0, 1);

        // Reset while bit 3 is being processed: no done, then a clean operation.
        issue(8'h5A, 8'h3C, 1'b1, ADD);
        dc0 = done_count;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3 * WIDTH) @(negedge clk);
        check("reset_no_done", done_count - dc0, 0);
        issue(8'h12, 8'h34, 1'b0, SUB);
        issue(8'hC8, 8'h64, 1'b1, ADD);

        // Back-to-back with start held high.
        wait_idle(4 * WIDTH);
        dc0 = done_count;
        b2b_mode = 1'b1;
        randomize_inputs();
        bus.start = 1'b1;
        n = 0;
        while (done_count - dc0 < 1000 && n < 1000 * (WIDTH + 4)) begin
            @(negedge clk);
            randomize_inputs();
            n++;
        end
        bus.start = 1'b0;
        b2b_mode = 1'b0;
        check("b2b_done_count", done_count - dc0, 1000);

        wait_idle(4 * WIDTH);
        check("queue_empty_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
